// File: rtl/regfile_hilo.sv
// Architectural GPR file (32x32, r0 hardwired to zero) plus HI/LO pair, written from WB.
// Define RF_BYPASS_EN to make every read port write-through for same-cycle writes.
module regfile_hilo #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int WB_TO_RF_WD = 38
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
  input  logic [ADDR_W-1:0]      raddr1,
  output logic [DATA_W-1:0]      rdata1,
  input  logic [ADDR_W-1:0]      raddr2,
  output logic [DATA_W-1:0]      rdata2,
  input  logic                   hi_we,
  input  logic                   lo_we,
  input  logic [DATA_W-1:0]      hi_i,
  input  logic [DATA_W-1:0]      lo_i,
  output logic [DATA_W-1:0]      hi_o,
  output logic [DATA_W-1:0]      lo_o,
  output logic [15:0]            wr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              gpr_commit;

  logic [DATA_W-1:0] gpr_q [DEPTH];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;

  assign wb_we    = wb_to_rf_bus[WB_TO_RF_WD-1];
  assign wb_waddr = wb_to_rf_bus[DATA_W +: ADDR_W];
  assign wb_wdata = wb_to_rf_bus[DATA_W-1:0];

  // Writes to r0 are architectural no-ops and must not count as commits.
  assign gpr_commit = wb_we && (wb_waddr != '0);

  // NOTE: the storage array is reset too, because software may read any GPR
  // before writing it and the zero-after-reset value is architecturally visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (gpr_commit) begin
      // NOTE: non-blocking assignment keeps every register update on the same edge.
      gpr_q[wb_waddr] <= wb_wdata;
    end
  end

  always_comb begin
    // NOTE: each comb output gets a default first so no path can infer a latch.
    hi_d     = hi_q;
    lo_d     = lo_q;
    wr_cnt_d = wr_cnt_q;
    if (hi_we)      hi_d     = hi_i;
    if (lo_we)      lo_d     = lo_i;
    if (gpr_commit) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      wr_cnt_q <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign wr_cnt = wr_cnt_q;

`ifdef RF_BYPASS_EN
  // Write-through: a same-cycle write to the addressed register wins over storage.
  always_comb begin
    rdata1 = gpr_q[raddr1];
    rdata2 = gpr_q[raddr2];
    hi_o   = hi_we ? hi_i : hi_q;
    lo_o   = lo_we ? lo_i : lo_q;
    if (gpr_commit && (wb_waddr == raddr1)) rdata1 = wb_wdata;
    if (gpr_commit && (wb_waddr == raddr2)) rdata2 = wb_wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end
`else
  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : gpr_q[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : gpr_q[raddr2];
    hi_o   = hi_q;
    lo_o   = lo_q;
  end
`endif

endmodule

// File: tb/tb_regfile_hilo.sv
// Self-checking bench for regfile_hilo: directed plan steps plus randomized traffic
// checked against an array-based architectural model; honours RF_BYPASS_EN.
module tb_regfile_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        hi_we, lo_we;
  logic [31:0] hi_i, lo_i, hi_o, lo_o;
  logic [15:0] wr_cnt;

  int checks   = 0;
  int failures = 0;

  // architectural model
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;
  int          m_cnt;

  regfile_hilo dut (
    .clk          (clk),
    .rst          (rst),
    .wb_to_rf_bus ({we, waddr, wdata}),
    .raddr1       (raddr1),
    .rdata1       (rdata1),
    .raddr2       (raddr2),
    .rdata2       (rdata2),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .hi_i         (hi_i),
    .lo_i         (lo_i),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .wr_cnt       (wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi  = 32'h0;
    m_lo  = 32'h0;
    m_cnt = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (rst || ra == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (we && waddr == ra) return wdata;
`endif
    return m_gpr[ra];
  endfunction

  function automatic logic [31:0] exp_hi();
    if (rst) return 32'h0;
`ifdef RF_BYPASS_EN
    if (hi_we) return hi_i;
`endif
    return m_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
    if (rst) return 32'h0;
`ifdef RF_BYPASS_EN
    if (lo_we) return lo_i;
`endif
    return m_lo;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rdata1"}, rdata1, exp_rd(raddr1));
    check({tag, ".rdata2"}, rdata2, exp_rd(raddr2));
    check({tag, ".hi_o"},   hi_o,   exp_hi());
    check({tag, ".lo_o"},   lo_o,   exp_lo());
    check({tag, ".wr_cnt"}, {16'h0, wr_cnt}, m_cnt[15:0]);
  endtask

  // One rising edge; model commits from the same inputs the DUT sampled.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (we && waddr != 5'd0) begin
        m_gpr[waddr] = wdata;
        m_cnt        = (m_cnt + 1) % 65536;
      end
      if (hi_we) m_hi = hi_i;
      if (lo_we) m_lo = lo_i;
    end
    #1;
  endtask

  task automatic idle();
    we = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; idle();
    waddr = 5'd0; wdata = 32'h0; raddr1 = 5'd0; raddr2 = 5'd0;
    hi_i = 32'h0; lo_i = 32'h0;
    model_reset();
    #12;
    raddr1 = 5'd5; raddr2 = 5'd31;
    #1 check_all("reset_init");
    cycle();
    rst = 1'b0;

    // Reset mid-cycle clears stored state without a clock edge
    we = 1'b1; waddr = 5'd5; wdata = 32'h1234;
    hi_we = 1'b1; hi_i = 32'hCAFE0001; lo_we = 1'b1; lo_i = 32'hCAFE0002;
    cycle();
    idle();
    raddr1 = 5'd5; raddr2 = 5'd5;
    #1 check_all("pre_reset");
    #2 rst = 1'b1;
    #1;
    check("async_rst.rdata1", rdata1, 32'h0);
    check("async_rst.hi_o",   hi_o,   32'h0);
    check("async_rst.lo_o",   lo_o,   32'h0);
    check("async_rst.wr_cnt", {16'h0, wr_cnt}, 32'h0);
    model_reset();
    // write held during reset must be dropped
    we = 1'b1; waddr = 5'd9; wdata = 32'h99999999;
    cycle();
    rst = 1'b0; idle();
    raddr1 = 5'd9;
    #1 check_all("rst_drop");

    // Basic write/read
    we = 1'b1; waddr = 5'd8; wdata = 32'hDEADBEEF;
    cycle();
    idle(); raddr1 = 5'd8; raddr2 = 5'd8;
    #1 check_all("basic");
    check("basic.cnt_is_1", {16'h0, wr_cnt}, 32'd1);

    // Zero register
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
    cycle();
    idle();
    #1 check_all("zero_reg");
    check("zero_reg.cnt_same", {16'h0, wr_cnt}, 32'd1);

    // HI/LO independence
    hi_we = 1'b1; hi_i = 32'hAAAA0000; lo_i = 32'h55555555;
    cycle();
    idle();
    #1 check_all("hi_only");
    hi_we = 1'b1; lo_we = 1'b1; hi_i = 32'd1; lo_i = 32'd2;
    cycle();
    idle();
    #1 check("hilo_both.hi", hi_o, 32'd1);
    check("hilo_both.lo", lo_o, 32'd2);

    // Same-cycle read/write of one register
    we = 1'b1; waddr = 5'd3; wdata = 32'd5;
    cycle();
    wdata = 32'd9; raddr1 = 5'd3;
    #1;
`ifdef RF_BYPASS_EN
    check("same_cycle.before", rdata1, 32'd9);
`else
    check("same_cycle.before", rdata1, 32'd5);
`endif
    check_all("same_cycle.model");
    cycle();
    idle();
    #1 check("same_cycle.after", rdata1, 32'd9);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      we     = 1'($urandom_range(0, 1));
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      hi_we  = 1'($urandom_range(0, 1));
      lo_we  = 1'($urandom_range(0, 1));
      hi_i   = $urandom;
      lo_i   = $urandom;
      #1 check_all($sformatf("rand%0d", i));
      cycle();
    end
    idle();

    // Counter wrap
    n = 65535 - m_cnt;
    we = 1'b1; waddr = 5'd1;
    for (int i = 0; i < n; i++) begin
      wdata = i;
      cycle();
    end
    idle();
    #1 check("wrap.ffff", {16'h0, wr_cnt}, 32'h0000FFFF);
    we = 1'b1; waddr = 5'd1; wdata = 32'h0BADF00D;
    cycle();
    idle(); raddr1 = 5'd1;
    #1 check("wrap.zero", {16'h0, wr_cnt}, 32'h0);
    check_all("wrap.final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
